// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-RAM arbiter.
// Holds the FSM states, read-return owner encoding and starvation limit.
package dmem_arb_pkg;

   typedef enum logic {
      ARB,
      FORCE
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE,
      CORE,
      EXT
   } owner_t;

   localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: saturating count of denied external cycles.
// hit flags the last denied cycle before a forced grant.
module dmem_arb_starve_cnt
   import dmem_arb_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam logic [7:0] LIM = 8'(LIMIT);

   logic [7:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && cnt_q != LIM) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign hit = (cnt_q == LIM - 8'd1);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the core and an external port.
// Statistics counters are built only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int data_size    = 1024,
   parameter int address_size = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic [address_size-1:0]       c_daddr,
   input  logic [address_size-1:0]       c_ddata_w,
   input  logic                          c_MemRead,
   input  logic                          c_MemWrite,
   output logic [address_size-1:0]       c_ddata_r,
   output logic                          c_stall,
   input  logic                          e_req,
   input  logic                          e_we,
   input  logic [address_size-1:0]       e_addr,
   input  logic [address_size-1:0]       e_wdata,
   output logic                          e_gnt,
   output logic                          e_rvalid,
   output logic [address_size-1:0]       e_rdata,
   output logic [$clog2(data_size)-1:0]  m_address,
   output logic [address_size-1:0]       m_data,
   output logic                          m_wren,
   output logic                          m_wread,
   input  logic [address_size-1:0]       m_salida,
   output logic [15:0]                   stat_ext_grants,
   output logic [15:0]                   stat_stalls
);

   localparam int AW = $clog2(data_size);

   arb_state_t              state_q, state_d;
   owner_t                  owner, rd_owner_q;
   logic                    c_req, hit;
   logic [address_size-1:0] owner_addr;
   logic                    addr_unused;

   assign c_req = c_MemRead | c_MemWrite;

   // Outputs are held quiet while reset is low so no stale strobe escapes.
   always_comb begin
      owner   = NONE;
      e_gnt   = 1'b0;
      c_stall = 1'b0;
      if (RESET_N) begin
         priority case (1'b1)
            state_q == FORCE: begin
               owner   = EXT;
               e_gnt   = 1'b1;
               c_stall = c_req;
            end
            c_req: owner = CORE;
            e_req: begin
               owner = EXT;
               e_gnt = 1'b1;
            end
            default: owner = NONE;
         endcase
      end
   end

   always_comb begin
      owner_addr = '0;
      m_data     = '0;
      m_wren     = 1'b0;
      m_wread    = 1'b0;
      unique case (owner)
         CORE: begin
            owner_addr = c_daddr;
            m_data     = c_ddata_w;
            m_wren     = c_MemWrite;
            m_wread    = c_MemRead & ~c_MemWrite;
         end
         EXT: begin
            owner_addr = e_addr;
            m_data     = e_wdata;
            m_wren     = e_req & e_we;
            m_wread    = e_req & ~e_we;
         end
         default: owner_addr = '0;
      endcase
   end

   assign m_address   = owner_addr[AW+1:2];
   assign addr_unused = ^{owner_addr[address_size-1:AW+2],
                          owner_addr[1:0]};

   always_comb begin
      state_d = ARB;
      if (state_q == ARB && e_req && !e_gnt && hit) begin
         state_d = FORCE;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= ARB;
         rd_owner_q <= NONE;
      end else begin
         state_q    <= state_d;
         rd_owner_q <= m_wread ? owner : NONE;
      end
   end

   dmem_arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk   (CLK),
      .rst_n (RESET_N),
      .inc   (e_req & ~e_gnt),
      .clr   (~e_req | e_gnt),
      .hit   (hit)
   );

   assign c_ddata_r = m_salida;
   assign e_rdata   = m_salida;
   assign e_rvalid  = RESET_N && (rd_owner_q == EXT);

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         stat_ext_grants <= '0;
         stat_stalls     <= '0;
      end else begin
         if (e_gnt && e_req && stat_ext_grants != 16'hFFFF) begin
            stat_ext_grants <= stat_ext_grants + 16'd1;
         end
         if (c_stall && stat_stalls != 16'hFFFF) begin
            stat_stalls <= stat_stalls + 16'd1;
         end
      end
   end
`else
   assign stat_ext_grants = '0;
   assign stat_stalls     = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the data-RAM arbiter.
// Includes a one-cycle-latency RAM model behind the m_* port.
module tb_dmem_arbiter;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [31:0] c_daddr, c_ddata_w, c_ddata_r;
   logic        c_MemRead, c_MemWrite, c_stall;
   logic        e_req, e_we, e_gnt, e_rvalid;
   logic [31:0] e_addr, e_wdata, e_rdata;
   logic [9:0]  m_address;
   logic [31:0] m_data, m_salida;
   logic        m_wren, m_wread;
   logic [15:0] stat_ext_grants, stat_stalls;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:1023];

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (m_wren) mem[m_address] <= m_data;
      if (m_wread) m_salida <= mem[m_address];
   end

   dmem_arbiter dut (
      .CLK             (CLK),
      .RESET_N         (RESET_N),
      .c_daddr         (c_daddr),
      .c_ddata_w       (c_ddata_w),
      .c_MemRead       (c_MemRead),
      .c_MemWrite      (c_MemWrite),
      .c_ddata_r       (c_ddata_r),
      .c_stall         (c_stall),
      .e_req           (e_req),
      .e_we            (e_we),
      .e_addr          (e_addr),
      .e_wdata         (e_wdata),
      .e_gnt           (e_gnt),
      .e_rvalid        (e_rvalid),
      .e_rdata         (e_rdata),
      .m_address       (m_address),
      .m_data          (m_data),
      .m_wren          (m_wren),
      .m_wread         (m_wread),
      .m_salida        (m_salida),
      .stat_ext_grants (stat_ext_grants),
      .stat_stalls     (stat_stalls)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic idle();
      c_daddr    = '0;
      c_ddata_w  = '0;
      c_MemRead  = 1'b0;
      c_MemWrite = 1'b0;
      e_req      = 1'b0;
      e_we       = 1'b0;
      e_addr     = '0;
      e_wdata    = '0;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      idle();
      step();
      RESET_N = 1'b1;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      idle();
      e_req = 1'b1;
      step();
      mid();
      total++;
      if ({e_gnt, c_stall, m_wren, m_wread, e_rvalid} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctl got=%b want=00000",
                  {e_gnt, c_stall, m_wren, m_wread, e_rvalid});
      end
      total++;
      if ({stat_ext_grants, stat_stalls} !== 32'h0) begin
         bad++;
         $display("FAIL reset_stats got=%h want=0",
                  {stat_ext_grants, stat_stalls});
      end
      step();
      RESET_N = 1'b1;
      idle();
   endtask

   task automatic test_ext_write_read();
      e_req   = 1'b1;
      e_we    = 1'b1;
      e_addr  = 32'h0000_0010;
      e_wdata = 32'hDEAD_BEEF;
      mid();
      total++;
      if ({e_gnt, m_wren, m_wread} !== 3'b110 || m_address !== 10'd4
          || m_data !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL ext_write gnt/wr/rd=%b addr=%0d data=%h want 110 4 deadbeef",
                  {e_gnt, m_wren, m_wread}, m_address, m_data);
      end
      step();
      e_we = 1'b0;
      mid();
      total++;
      if ({e_gnt, m_wren, m_wread} !== 3'b101 || m_address !== 10'd4) begin
         bad++;
         $display("FAIL ext_read gnt/wr/rd=%b addr=%0d want 101 4",
                  {e_gnt, m_wren, m_wread}, m_address);
      end
      step();
      idle();
      mid();
      total++;
      if (e_rvalid !== 1'b1 || e_rdata !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL ext_rvalid got=%b %h want=1 deadbeef",
                  e_rvalid, e_rdata);
      end
      step();
      mid();
      total++;
      if (e_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL ext_rvalid_pulse got=%b want=0", e_rvalid);
      end
      step();
   endtask

   task automatic test_starve();
      c_MemRead = 1'b1;
      c_daddr   = 32'h0000_0040;
      e_req     = 1'b1;
      e_we      = 1'b0;
      e_addr    = 32'h0000_0010;
      for (int i = 1; i <= 9; i++) begin
         mid();
         total++;
         if (i < 9) begin
            if (e_gnt !== 1'b0 || c_stall !== 1'b0 || m_address !== 10'd16
                || m_wread !== 1'b1) begin
               bad++;
               $display("FAIL starve_deny cyc=%0d gnt=%b stall=%b addr=%0d want 0 0 16",
                        i, e_gnt, c_stall, m_address);
            end
         end else begin
            if (e_gnt !== 1'b1 || c_stall !== 1'b1 || m_address !== 10'd4
                || m_wread !== 1'b1) begin
               bad++;
               $display("FAIL starve_force gnt=%b stall=%b addr=%0d want 1 1 4",
                        e_gnt, c_stall, m_address);
            end
         end
         step();
      end
      e_req = 1'b0;
      mid();
      total++;
      if (e_gnt !== 1'b0 || c_stall !== 1'b0 || m_address !== 10'd16
          || m_wread !== 1'b1) begin
         bad++;
         $display("FAIL starve_core_next gnt=%b stall=%b addr=%0d want 0 0 16",
                  e_gnt, c_stall, m_address);
      end
      total++;
      if (e_rvalid !== 1'b1 || e_rdata !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL starve_rdata got=%b %h want=1 deadbeef",
                  e_rvalid, e_rdata);
      end
      step();
      idle();
      step();
   endtask

   task automatic test_rw_both();
      c_MemRead  = 1'b1;
      c_MemWrite = 1'b1;
      c_daddr    = 32'h0000_0020;
      c_ddata_w  = 32'h1234_5678;
      mid();
      total++;
      if ({m_wren, m_wread, e_gnt} !== 3'b100 || m_address !== 10'd8) begin
         bad++;
         $display("FAIL rw_both wr/rd/gnt=%b addr=%0d want 100 8",
                  {m_wren, m_wread, e_gnt}, m_address);
      end
      step();
      c_MemWrite = 1'b0;
      step();
      idle();
      mid();
      total++;
      if (c_ddata_r !== 32'h1234_5678 || e_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL core_read got=%h rvalid=%b want 12345678 0",
                  c_ddata_r, e_rvalid);
      end
      step();
   endtask

   task automatic test_reset_mid();
      e_req  = 1'b1;
      e_we   = 1'b0;
      e_addr = 32'h0000_0010;
      step();
      idle();
      RESET_N = 1'b0;
      mid();
      total++;
      if ({e_rvalid, e_gnt, c_stall, m_wren, m_wread} !== 5'b0) begin
         bad++;
         $display("FAIL reset_mid_in got=%b want=00000",
                  {e_rvalid, e_gnt, c_stall, m_wren, m_wread});
      end
      step();
      RESET_N = 1'b1;
      mid();
      total++;
      if ({e_rvalid, e_gnt, c_stall, m_wren, m_wread} !== 5'b0) begin
         bad++;
         $display("FAIL reset_mid_after got=%b want=00000",
                  {e_rvalid, e_gnt, c_stall, m_wren, m_wread});
      end
      step();
   endtask

   task automatic test_drop();
      c_MemRead = 1'b1;
      c_daddr   = 32'h0000_0040;
      e_req     = 1'b1;
      e_addr    = 32'h0000_0014;
      for (int i = 0; i < 3; i++) begin
         mid();
         total++;
         if (e_gnt !== 1'b0) begin
            bad++;
            $display("FAIL drop_pre cyc=%0d gnt=%b want=0", i, e_gnt);
         end
         step();
      end
      e_req = 1'b0;
      step();
      e_req = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         mid();
         total++;
         if (e_gnt !== (i == 9) || c_stall !== (i == 9)) begin
            bad++;
            $display("FAIL drop_restart cyc=%0d gnt=%b stall=%b want=%b",
                     i, e_gnt, c_stall, i == 9);
         end
         step();
      end
      idle();
      step();
   endtask

   task automatic test_back_to_back();
      e_req = 1'b1;
      e_we  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e_addr  = 32'h100 + 32'(i * 4);
         e_wdata = 32'hA000_0000 + 32'(i);
         mid();
         total++;
         if (e_gnt !== 1'b1 || m_wren !== 1'b1
             || m_address !== 10'(64 + i)) begin
            bad++;
            $display("FAIL b2b_write i=%0d gnt=%b wr=%b addr=%0d want 1 1 %0d",
                     i, e_gnt, m_wren, m_address, 64 + i);
         end
         step();
      end
      e_we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         e_req  = (i < 4);
         e_addr = 32'h100 + 32'(i * 4);
         mid();
         if (i > 0) begin
            total++;
            if (e_rvalid !== 1'b1 || e_rdata !== 32'hA000_0000 + 32'(i - 1)) begin
               bad++;
               $display("FAIL b2b_read i=%0d rvalid=%b data=%h want 1 %h",
                        i, e_rvalid, e_rdata, 32'hA000_0000 + 32'(i - 1));
            end
         end
         step();
      end
      idle();
   endtask

   task automatic force_once();
      c_MemRead = 1'b1;
      c_daddr   = 32'h0000_0040;
      e_req     = 1'b1;
      e_we      = 1'b0;
      e_addr    = 32'h0000_0010;
      repeat (9) step();
      idle();
      step();
   endtask

   task automatic test_stats();
      logic [15:0] want_g, want_s;
      do_reset();
      force_once();
      force_once();
      e_req = 1'b1;
      e_we  = 1'b1;
      repeat (3) step();
      idle();
      mid();
`ifdef DMEM_ARB_STATS_EN
      want_g = 16'd5;
      want_s = 16'd2;
`else
      want_g = 16'd0;
      want_s = 16'd0;
`endif
      total++;
      if (stat_ext_grants !== want_g) begin
         bad++;
         $display("FAIL stat_grants got=%0d want=%0d", stat_ext_grants, want_g);
      end
      total++;
      if (stat_stalls !== want_s) begin
         bad++;
         $display("FAIL stat_stalls got=%0d want=%0d", stat_stalls, want_s);
      end
      step();
   endtask

   initial begin
      m_salida = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      RESET_N = 1'b0;
      idle();
      step();
      test_reset();
      test_ext_write_read();
      test_starve();
      test_rw_both();
      test_reset_mid();
      test_drop();
      test_back_to_back();
      test_stats();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
